// File: rtl/i2c_reg_access_if.sv
// Request/response port and i2c_master cmd/data/status port of the register-access sequencer.
// The master modport drives the transaction; the slave modport serves it.
interface i2c_req_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic       rsp_timeout;

    modport master (
        output req_valid, req_write, req_dev_addr, req_reg_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
    );
    modport slave (
        input  req_valid, req_write, req_dev_addr, req_reg_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
    );
endinterface

interface i2c_mstr_if;
    logic [6:0] m_cmd_address;
    logic       m_cmd_start;
    logic       m_cmd_read;
    logic       m_cmd_write;
    logic       m_cmd_write_multiple;
    logic       m_cmd_stop;
    logic       m_cmd_valid;
    logic       m_cmd_ready;
    logic [7:0] m_data_tdata;
    logic       m_data_tvalid;
    logic       m_data_tlast;
    logic       m_data_tready;
    logic [7:0] s_data_tdata;
    logic       s_data_tvalid;
    logic       s_data_tlast;
    logic       s_data_tready;
    logic       i2c_missed_ack;
    logic       i2c_busy;

    modport master (
        output m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
               m_cmd_stop, m_cmd_valid, m_data_tdata, m_data_tvalid, m_data_tlast, s_data_tready,
        input  m_cmd_ready, m_data_tready, s_data_tdata, s_data_tvalid, s_data_tlast,
               i2c_missed_ack, i2c_busy
    );
    modport slave (
        input  m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
               m_cmd_stop, m_cmd_valid, m_data_tdata, m_data_tvalid, m_data_tlast, s_data_tready,
        output m_cmd_ready, m_data_tready, s_data_tdata, s_data_tvalid, s_data_tlast,
               i2c_missed_ack, i2c_busy
    );
endinterface

// File: rtl/i2c_reg_access.sv
// Turns one register write/read request into i2c_master cmd/data beats and returns one response;
// all outputs registered, every wait state bounded by TIMEOUT_CYCLES, response held until rsp_ready.
module i2c_reg_access #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_WIDTH       = 20
) (
    input  logic      clk,
    input  logic      rst_n,
    i2c_req_if.slave  host,
    i2c_mstr_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, W_CMD, W_D0, W_D1, R_CMD1, R_D0, R_CMD2, R_DATA, WAIT_IDLE, RESP
    } state_t;

    typedef struct packed {
        logic       write;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } req_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] TO_MAX  = TO_WIDTH'(TIMEOUT_CYCLES);

    state_t              state, state_nxt;
    req_t                req_q, req_nxt;
    logic                err_q, err_nxt;
    logic [7:0]          rdata_q, rdata_nxt;
    logic [TO_WIDTH-1:0] to_cnt, to_cnt_nxt;
    logic                timeout_hit, in_wait, cmd_nxt, data_nxt, enter_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            to_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            req_q   <= req_nxt;
            err_q   <= err_nxt;
            rdata_q <= rdata_nxt;
            to_cnt  <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_nxt     = req_q;
        err_nxt     = err_q;
        rdata_nxt   = rdata_q;
        timeout_hit = 1'b0;
        in_wait     = (state != IDLE) && (state != RESP);
        if (state != IDLE && bus.i2c_missed_ack) err_nxt = 1'b1;

        unique case (state)
            IDLE: if (host.req_valid && host.req_ready) begin
                req_nxt   = '{write: host.req_write, dev: host.req_dev_addr,
                              reg_addr: host.req_reg_addr, wdata: host.req_wdata};
                rdata_nxt = '0;
                state_nxt = host.req_write ? W_CMD : R_CMD1;
            end
            W_CMD:  if (bus.m_cmd_valid && bus.m_cmd_ready)     state_nxt = W_D0;
            W_D0:   if (bus.m_data_tvalid && bus.m_data_tready) state_nxt = W_D1;
            W_D1:   if (bus.m_data_tvalid && bus.m_data_tready) state_nxt = WAIT_IDLE;
            R_CMD1: if (bus.m_cmd_valid && bus.m_cmd_ready)     state_nxt = R_D0;
            R_D0:   if (bus.m_data_tvalid && bus.m_data_tready) state_nxt = R_CMD2;
            R_CMD2: if (bus.m_cmd_valid && bus.m_cmd_ready)     state_nxt = R_DATA;
            R_DATA: if (bus.s_data_tvalid && bus.s_data_tready) begin
                rdata_nxt = bus.s_data_tdata;
                state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: if (!bus.i2c_busy) state_nxt = RESP;
            RESP: if (host.rsp_valid && host.rsp_ready) begin
                err_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Timeout overrides any handshake seen in the same cycle.
        if (in_wait && to_cnt >= TO_LAST) begin
            timeout_hit = 1'b1;
            state_nxt   = RESP;
        end

        if (state_nxt != state)                to_cnt_nxt = '0;
        else if (in_wait && to_cnt != TO_MAX) to_cnt_nxt = to_cnt + TO_WIDTH'(1);
        else                                   to_cnt_nxt = to_cnt;

        cmd_nxt    = (state_nxt == W_CMD) || (state_nxt == R_CMD1) || (state_nxt == R_CMD2);
        data_nxt   = (state_nxt == W_D0) || (state_nxt == W_D1) || (state_nxt == R_D0);
        enter_resp = (state_nxt == RESP) && (state != RESP);
    end

    // Outputs are decoded from the next state so valids drop on the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host.req_ready           <= 1'b0;
            host.rsp_valid           <= 1'b0;
            host.rsp_rdata           <= '0;
            host.rsp_error           <= 1'b0;
            host.rsp_timeout         <= 1'b0;
            bus.m_cmd_valid          <= 1'b0;
            bus.m_cmd_address        <= '0;
            bus.m_cmd_start          <= 1'b0;
            bus.m_cmd_read           <= 1'b0;
            bus.m_cmd_write          <= 1'b0;
            bus.m_cmd_write_multiple <= 1'b0;
            bus.m_cmd_stop           <= 1'b0;
            bus.m_data_tvalid        <= 1'b0;
            bus.m_data_tdata         <= '0;
            bus.m_data_tlast         <= 1'b0;
            bus.s_data_tready        <= 1'b0;
        end else begin
            host.req_ready           <= (state_nxt == IDLE);
            host.rsp_valid           <= (state_nxt == RESP);
            bus.m_cmd_valid          <= cmd_nxt;
            bus.m_cmd_address        <= cmd_nxt ? req_nxt.dev : '0;
            bus.m_cmd_start          <= cmd_nxt;
            bus.m_cmd_read           <= (state_nxt == R_CMD2);
            bus.m_cmd_write          <= (state_nxt == R_CMD1);
            bus.m_cmd_write_multiple <= (state_nxt == W_CMD);
            bus.m_cmd_stop           <= (state_nxt == W_CMD) || (state_nxt == R_CMD2);
            bus.m_data_tvalid        <= data_nxt;
            bus.m_data_tdata         <= (state_nxt == W_D1) ? req_nxt.wdata :
                                        data_nxt ? req_nxt.reg_addr : '0;
            bus.m_data_tlast         <= (state_nxt == W_D1) || (state_nxt == R_D0);
            bus.s_data_tready        <= (state_nxt == R_DATA);
            if (enter_resp) begin
                host.rsp_error   <= err_nxt | timeout_hit;
                host.rsp_timeout <= timeout_hit;
                host.rsp_rdata   <= (err_nxt | timeout_hit) ? '0 : rdata_nxt;
            end else if (state_nxt != RESP) begin
                host.rsp_error   <= 1'b0;
                host.rsp_timeout <= 1'b0;
                host.rsp_rdata   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_reg_access.sv
// Bench for i2c_reg_access: randomized register traffic against a bus-level i2c_master/slave
// model, checked against a request-level register-file reference.
module tb_i2c_reg_access;
    localparam int         TO  = 64;
    localparam logic [6:0] DEV = 7'h70;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_req_if  host();
    i2c_mstr_if bus();

    i2c_reg_access #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .host(host.slave), .bus(bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  slave_mem[256];
    logic [7:0]  ref_mem[256];
    logic [10:0] cmd_log[$];
    logic [8:0]  dat_log[$];
    int overlap   = 0;
    bit cmd_stall = 1'b0;
    bit rd_hold   = 1'b0;
    bit model_rst = 1'b0;

    // Behavioural i2c_master plus a single register slave at DEV.
    initial begin
        logic [6:0] cur_dev;
        logic [7:0] ptr, rd_byte;
        bit cur_wm, rd_pend, rd_done, set_busy;
        int didx, rd_dly, nack_cnt, drop_cnt;
        cur_dev = '0; ptr = '0; rd_byte = '0; cur_wm = 0; rd_pend = 0; rd_done = 0;
        set_busy = 0; didx = 0; rd_dly = 0; nack_cnt = 0; drop_cnt = 0;
        bus.m_cmd_ready = 0; bus.m_data_tready = 0; bus.s_data_tdata = '0;
        bus.s_data_tvalid = 0; bus.s_data_tlast = 0; bus.i2c_missed_ack = 0; bus.i2c_busy = 0;
        forever begin
            @(posedge clk); #1;
            if (model_rst) begin
                rd_pend = 0; rd_done = 0; set_busy = 0; nack_cnt = 0; drop_cnt = 0;
                bus.s_data_tvalid = 0; bus.i2c_busy = 0; bus.i2c_missed_ack = 0;
            end else begin
                if (set_busy) begin bus.i2c_busy = 1; set_busy = 0; end
                bus.i2c_missed_ack = 0;
                if (nack_cnt > 0) begin nack_cnt--; if (nack_cnt == 0) bus.i2c_missed_ack = 1; end
                if (drop_cnt > 0) begin drop_cnt--; if (drop_cnt == 0) bus.i2c_busy = 0; end
                if (rd_done) begin
                    bus.s_data_tvalid = 0; rd_done = 0; rd_pend = 0;
                    drop_cnt = $urandom_range(2, 6);
                end else if (rd_pend && !rd_hold && !bus.s_data_tvalid) begin
                    if (rd_dly > 0) rd_dly--;
                    else begin
                        bus.s_data_tvalid = 1; bus.s_data_tdata = rd_byte; bus.s_data_tlast = 1;
                    end
                end
            end
            bus.m_cmd_ready   = !cmd_stall && ($urandom_range(0, 3) != 0);
            bus.m_data_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.m_cmd_valid && bus.m_data_tvalid) overlap++;
            if (rst_n && !model_rst) begin
                if (bus.m_cmd_valid && bus.m_cmd_ready) begin
                    cmd_log.push_back({bus.m_cmd_address, bus.m_cmd_start, bus.m_cmd_read,
                                       bus.m_cmd_write, bus.m_cmd_write_multiple, bus.m_cmd_stop});
                    set_busy = 1; cur_dev = bus.m_cmd_address; cur_wm = bus.m_cmd_write_multiple;
                    didx = 0;
                    if (cur_dev != DEV) nack_cnt = $urandom_range(1, 3);
                    if (bus.m_cmd_read) begin
                        if (cur_dev == DEV) begin
                            rd_pend = 1; rd_dly = $urandom_range(0, 4); rd_byte = slave_mem[ptr];
                        end else drop_cnt = 3;
                    end
                end
                if (bus.m_data_tvalid && bus.m_data_tready) begin
                    dat_log.push_back({bus.m_data_tlast, bus.m_data_tdata});
                    if (cur_dev == DEV) begin
                        if (didx == 0) ptr = bus.m_data_tdata;
                        else slave_mem[ptr] = bus.m_data_tdata;
                    end
                    didx++;
                    if (bus.m_data_tlast && cur_wm) drop_cnt = $urandom_range(2, 6);
                end
                if (bus.s_data_tvalid && bus.s_data_tready) rd_done = 1;
            end
        end
    end

    task automatic send_req(input bit wr, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [7:0] wd);
        int n = 0;
        bit acc = 0;
        host.req_valid = 1; host.req_write = wr; host.req_dev_addr = dev;
        host.req_reg_addr = ra; host.req_wdata = wd;
        while (!acc && n < 200) begin
            @(negedge clk); acc = host.req_ready;
            @(posedge clk); #1; n++;
        end
        host.req_valid = 0;
        check("req_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!host.rsp_valid && n < 400) begin @(posedge clk); #1; n++; end
        check("rsp_seen", 32'(host.rsp_valid), 32'd1);
    endtask

    task automatic take_rsp(input int hold, output logic [7:0] rd, output bit err, output bit to);
        logic [9:0] first;
        int bad = 0;
        first = {host.rsp_rdata, host.rsp_error, host.rsp_timeout};
        if (hold > 0) begin
            host.req_valid = 1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if ({host.rsp_rdata, host.rsp_error, host.rsp_timeout} != first ||
                    !host.rsp_valid || host.req_ready) bad++;
            end
            host.req_valid = 0;
            check("rsp_hold_stable", 32'(bad), 32'd0);
        end
        host.rsp_ready = 1;
        rd = host.rsp_rdata; err = host.rsp_error; to = host.rsp_timeout;
        @(posedge clk); #1;
        host.rsp_ready = 0;
        check("rsp_valid_drop", 32'(host.rsp_valid), 32'd0);
        check("req_ready_back", 32'(host.req_ready), 32'd1);
    endtask

    task automatic do_req(input bit wr, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd, input int hold);
        logic [10:0] ec[$];
        logic [8:0]  ed[$];
        logic [7:0]  exp_rd, rd;
        bit present, exp_err, exp_to, err, to;
        present = (dev == DEV);
        if (wr) begin
            exp_err = !present; exp_to = 0; exp_rd = '0;
            if (present) ref_mem[ra] = wd;
            ec.push_back({dev, 5'b10011});
            ed.push_back({1'b0, ra}); ed.push_back({1'b1, wd});
        end else begin
            exp_err = !present; exp_to = !present; exp_rd = present ? ref_mem[ra] : 8'h00;
            ec.push_back({dev, 5'b10100}); ec.push_back({dev, 5'b11001});
            ed.push_back({1'b1, ra});
        end
        cmd_log.delete(); dat_log.delete();
        send_req(wr, dev, ra, wd);
        wait_rsp();
        take_rsp(hold, rd, err, to);
        check($sformatf("rdata wr=%0d dev=%0h reg=%0h", wr, dev, ra), 32'(rd), 32'(exp_rd));
        check("rsp_error", 32'(err), 32'(exp_err));
        check("rsp_timeout", 32'(to), 32'(exp_to));
        check("cmd_count", 32'(cmd_log.size()), 32'(ec.size()));
        for (int i = 0; i < ec.size() && i < cmd_log.size(); i++)
            check($sformatf("cmd%0d", i), 32'(cmd_log[i]), 32'(ec[i]));
        check("data_count", 32'(dat_log.size()), 32'(ed.size()));
        for (int i = 0; i < ed.size() && i < dat_log.size(); i++)
            check($sformatf("data%0d", i), 32'(dat_log[i]), 32'(ed[i]));
        if (wr && present) check("slave_mem", 32'(slave_mem[ra]), 32'(wd));
    endtask

    initial begin
        logic [7:0] rd, ra;
        bit err, to;
        int t0, n;
        host.req_valid = 0; host.req_write = 0; host.req_dev_addr = '0;
        host.req_reg_addr = '0; host.req_wdata = '0; host.rsp_ready = 0;
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom); slave_mem[i] = ra; ref_mem[i] = ra;
        end
        slave_mem[8'h40] = 8'h7B; ref_mem[8'h40] = 8'h7B;

        repeat (3) @(posedge clk); #1;
        check("rst_req_ready", 32'(host.req_ready), 32'd0);
        check("rst_rsp", 32'({host.rsp_valid, host.rsp_error, host.rsp_timeout, host.rsp_rdata}), 32'd0);
        check("rst_cmd", 32'({bus.m_cmd_valid, bus.m_cmd_address, bus.m_cmd_start, bus.m_cmd_read,
                              bus.m_cmd_write, bus.m_cmd_write_multiple, bus.m_cmd_stop}), 32'd0);
        check("rst_data", 32'({bus.m_data_tvalid, bus.m_data_tdata, bus.m_data_tlast,
                               bus.s_data_tready}), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        check("req_ready_after_rst", 32'(host.req_ready), 32'd1);

        do_req(1, DEV, 8'h12, 8'h37, 0);
        do_req(0, DEV, 8'h40, 8'h00, 0);
        do_req(0, DEV, 8'h12, 8'h00, 0);
        do_req(1, 7'h01, 8'h05, 8'hA5, 0);
        check("bus_idle_after_nack", 32'(bus.i2c_busy), 32'd0);
        do_req(1, DEV, 8'h03, 8'h5C, 20);
        do_req(0, 7'h22, 8'h03, 8'h00, 0);

        for (int k = 0; k < 24; k++) begin
            logic [6:0] d;
            d = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 8'h6F)) : DEV;
            do_req(1'($urandom_range(0, 1)), d, 8'($urandom_range(0, 15)), 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? 3 : 0);
        end

        // Command port never accepts: abort after exactly TO cycles in W_CMD.
        cmd_stall = 1;
        cmd_log.delete(); dat_log.delete();
        send_req(1, DEV, 8'h09, 8'hEE);
        n = 0;
        while (!bus.m_cmd_valid && n < 50) begin @(posedge clk); #1; n++; end
        t0 = cyc;
        wait_rsp();
        check("timeout_latency", 32'(cyc - t0), 32'(TO));
        check("timeout_cmd_dropped", 32'(bus.m_cmd_valid), 32'd0);
        take_rsp(0, rd, err, to);
        check("timeout_flags", 32'({err, to, rd}), 32'h300);
        check("timeout_no_beats", 32'(cmd_log.size() + dat_log.size()), 32'd0);
        cmd_stall = 0;

        // Reset while waiting for read data, then a clean read.
        rd_hold = 1;
        send_req(0, DEV, 8'h07, 8'h00);
        n = 0;
        while (!bus.s_data_tready && n < 200) begin @(posedge clk); #1; n++; end
        check("reached_r_data", 32'(bus.s_data_tready), 32'd1);
        rst_n = 0; model_rst = 1;
        #2;
        check("midrst_outputs", 32'({host.req_ready, host.rsp_valid, bus.m_cmd_valid,
                                     bus.m_data_tvalid, bus.s_data_tready}), 32'd0);
        rd_hold = 0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        model_rst = 0;
        do_req(0, DEV, 8'h07, 8'h00, 0);
        do_req(0, DEV, 8'h12, 8'h00, 0);

        check("cmd_data_overlap", 32'(overlap), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
